// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces
// presses and releases over scan ticks, and reports the accepted key code.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_s1, rows;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx, col_nxt;
  logic [3:0]       cand, cand_nxt, code_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, rel, rel_nxt;
  logic             valid_nxt;
  logic             tick_c, hit_c;
  logic [1:0]       row_idx_c;
  logic [3:0]       samp_c;
  logic [CNT_W-1:0] cnt_inc_c, rel_inc_c;

  // Two-flop synchronizer; idle (all rows high) out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      rows   <= 4'hF;
    end else begin
      row_s1 <= row_in;
      rows   <= row_s1;
    end
  end

  // Free-running dwell divider; the tick is its last count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= tick_c ? '0 : div + DIV_W'(1);
  end

  assign tick_c    = (div == DIV_LAST);
  assign hit_c     = (rows != 4'hF);
  assign samp_c    = {row_idx_c, col_idx};
  assign cnt_inc_c = cnt + CNT_W'(1);
  assign rel_inc_c = rel + CNT_W'(1);

  // Lowest-index low row wins
  always_comb begin
    row_idx_c = 2'd3;
    if      (!rows[0]) row_idx_c = 2'd0;
    else if (!rows[1]) row_idx_c = 2'd1;
    else if (!rows[2]) row_idx_c = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  // Next-state logic; every decision is taken on a tick only
  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    rel_nxt   = rel;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    case (state)
      SCAN: begin
        if (tick_c) begin
          rel_nxt = '0;
          if (hit_c) begin
            cand_nxt = samp_c;
            if (CNT_TGT <= CNT_W'(1)) begin
              code_nxt  = samp_c;
              valid_nxt = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick_c) begin
          if (hit_c && (samp_c == cand)) begin
            if (cnt_inc_c >= CNT_TGT) begin
              code_nxt  = cand;
              valid_nxt = 1'b1;
              cnt_nxt   = '0;
              rel_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt = cnt_inc_c;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = SCAN;
          end
        end
      end
      HELD: begin
        // Any low row in the held column keeps the key held
        if (tick_c) begin
          if (hit_c) begin
            rel_nxt = '0;
          end else if (rel_inc_c >= CNT_TGT) begin
            rel_nxt   = '0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end else begin
            rel_nxt = rel_inc_c;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        rel_nxt   = '0;
        state_nxt = SCAN;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx   <= 2'd0;
      col_out   <= 4'b1110;
      cand      <= 4'h0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_idx   <= col_nxt;
      col_out   <= ~(4'b0001 << col_nxt);
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      rel       <= rel_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= (state_nxt == HELD);
    end
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per column dwell ("tick" period), legal range >= 4.
REQ-002 Parameter DEBOUNCE_CNT, default 8: consecutive agreeing ticks needed to accept a press or a release, legal range 1-255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}, a 4-bit hex value compatible with the LED decode path.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer before any use; "rows" below means the synchronized value.
REQ-011 A divider SHALL count 0..SCAN_DIV-1 and wrap; "tick" is the cycle where the divider equals SCAN_DIV-1.
REQ-012 Rows SHALL be sampled only on a tick, so each column has SCAN_DIV-1 cycles of settling time before its sample.
REQ-013 Column index SHALL advance 0->1->2->3->0 on each tick, and only in state SCAN; col_out = ~(4'b0001 << col_idx).
REQ-014 Row decode: the lowest-index low row wins; rows == 4'b1111 means no key.
REQ-015 State SCAN: on a tick with a key in the current column, latch cand = {row_idx, col_idx}, set debounce count to 1, and go to DEBOUNCE; the column does not advance.
REQ-016 DEBOUNCE_CNT == 1: the transition in REQ-015 SHALL go directly to the accept action of REQ-017.
REQ-017 State DEBOUNCE, per tick: if the sampled key equals cand, increment the count. When the count reaches DEBOUNCE_CNT: load key_code <= cand, pulse key_valid in the following cycle, and go to HELD.
REQ-018 State DEBOUNCE, per tick: if no key is sampled, or a different row is sampled, return to SCAN with the count cleared and key_code unchanged.
REQ-019 State HELD: key_held = 1 and the column stays fixed. Each tick with no key increments a release count; each tick with the key present clears it.
REQ-020 State HELD: when the release count reaches DEBOUNCE_CNT, go to SCAN, clear key_held, and advance the column by one.
REQ-021 While in HELD, a different row in the same column SHALL be ignored (no new key_valid) until release completes; at most one key_valid per press.
REQ-022 key_valid SHALL be exactly one clk cycle wide and SHALL never assert in two consecutive cycles.
REQ-023 key_code SHALL hold its value between accepted keys; it changes only on acceptance.
REQ-024 All counters SHALL saturate or reset explicitly; none may wrap into a false accept.

Reset
REQ-025 While rst = 1, outputs SHALL be: col_out = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0.
REQ-026 While rst = 1, internal state SHALL be: state = SCAN, divider = 0, debounce and release counts = 0, synchronizer flops = 4'b1111.
REQ-027 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort immediately with no key_valid pulse. After deassertion, scanning restarts from column 0.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-028 Reset then idle rows = 4'hF for 64 cycles -> col_out cycles 1110, 1101, 1011, 0111 every 4 clk; key_valid never asserts; key_code = 4'h0.
REQ-029 Clean press at row 1 while col 2 is driven, held for 40 cycles -> exactly one key_valid pulse with key_code = 4'h6, one cycle after the 3rd agreeing tick; key_held = 1 until 3 ticks after release.
REQ-030 Bounce: row 1 low for one tick, high for one tick, then stable low -> no pulse from the first contact; a single pulse on the 3rd consecutive agreeing tick.
REQ-031 Rows 0 and 2 low together at col 3 -> key_code = 4'h3 (row 0 wins); a single pulse.
REQ-032 Assert rst while in HELD with key 4'hF pressed -> outputs return to reset values immediately (asynchronously); after release of rst, with the key still pressed, a fresh debounce yields one pulse with key_code = 4'hF.
REQ-033 Two sequential presses, 4'h5 and then 4'hA, each with a full release in between -> two pulses; key_code reads 5 then A; no pulse is produced during the releases.
